// File: rtl/bus_tristate.sv
// bus_tristate: one-of-N lane selector onto a shared internal bus, registered
// and broadcast to every output lane.
module bus_tristate #(
  parameter int NUM_INPUT  = 8,
  parameter int NUM_OUTPUT = 8,
  parameter int SEL_BIT    = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_INPUT*DATA_WIDTH-1:0]  data_in,
  input  logic [SEL_BIT-1:0]               sel_in,
  output logic [NUM_OUTPUT*DATA_WIDTH-1:0] data_out
);
  logic [NUM_INPUT-1:0]  drv_en;
  logic [DATA_WIDTH-1:0] bus_d, bus_q;
  // Tri-state bus realised as one-hot AND-OR; no enable means the bus reads zero.
  for (genvar i = 0; i < NUM_INPUT; i++) begin : g_drv
    assign drv_en[i] = int'(sel_in) == i;
  end
  always_comb begin
    bus_d = '0;
    for (int i = 0; i < NUM_INPUT; i++)
      bus_d = bus_d | (drv_en[i] ? data_in[i*DATA_WIDTH +: DATA_WIDTH] : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus_q <= '0;
    else bus_q <= bus_d;
  assign data_out = {NUM_OUTPUT{bus_q}};
endmodule

// File: tb/tb_bus_tristate.sv
// tb_bus_tristate: directed plus random checks of bus_tristate (8-lane and 6-lane builds).
module tb_bus_tristate;
  logic        clk = 0;
  logic        rst_n = 1;
  logic [2:0]  sel = 0;
  logic [7:0]  lanes [8];
  logic [63:0] data_in;
  logic [63:0] out8;
  logic [47:0] out6;
  logic [7:0]  exp8, exp6;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;
  always_comb for (int i = 0; i < 8; i++) data_in[i*8 +: 8] = lanes[i];

  bus_tristate dut8 (.clk(clk), .rst_n(rst_n), .data_in(data_in), .sel_in(sel), .data_out(out8));
  bus_tristate #(.NUM_INPUT(6), .NUM_OUTPUT(6), .SEL_BIT(3), .DATA_WIDTH(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in[47:0]), .sel_in(sel), .data_out(out6));

  function automatic logic [7:0] pick(input int s, input int n);
    return (s < n) ? lanes[s] : 8'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    exp8 = rst_n ? pick(int'(sel), 8) : 8'h00;
    exp6 = rst_n ? pick(int'(sel), 6) : 8'h00;
    #1;
  endtask

  task automatic check(input string tag);
    checks++;
    assert (out8 === {8{exp8}}) passes++;
    else $error("FAIL %s n8 observed=%h expected=%h", tag, out8, {8{exp8}});
    checks++;
    assert (out6 === {6{exp6}}) passes++;
    else $error("FAIL %s n6 observed=%h expected=%h", tag, out6, {6{exp6}});
  endtask

  initial begin
    lanes = '{8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h88};
    exp8 = 0;
    exp6 = 0;
    #2 rst_n = 0;
    repeat (3) step();
    check("reset");
    @(negedge clk) rst_n = 1;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk) sel = 3'(s);
      step();
      check($sformatf("sweep%0d", s));
    end
    @(negedge clk) sel = 1;
    step();
    check("lat_before");
    @(negedge clk) sel = 2;
    #1 check("lat_hold");
    step();
    check("lat_after");
    @(negedge clk) begin sel = 3; lanes[3] = 8'h5A; end
    step();
    check("data_change");
    @(negedge clk) begin lanes[5] = 8'h77; lanes[0] = 8'h11; end
    step();
    check("other_lane");
    @(negedge clk) sel = 6;
    step();
    check("oor6");
    @(negedge clk) sel = 7;
    step();
    check("oor7");
    #2 rst_n = 0;
    #1 exp8 = 0;
    exp6 = 0;
    check("async_rst");
    #1 rst_n = 1;
    #1 check("rst_released_hold");
    step();
    check("rst_recover");
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) lanes[i] = 8'($urandom);
      sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) begin
        #1 rst_n = 0;
        #1 exp8 = 0;
        exp6 = 0;
        check("rand_rst");
        rst_n = 1;
      end
      step();
      check($sformatf("rand%0d", k));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
